// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, next-PC
// selects and the per-cycle pipeline action chosen by the controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    typedef enum logic [1:0] {
        ACT_SEQ      = 2'd0,
        ACT_BUBBLE   = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_FREEZE   = 2'd3
    } action_t;

    // A jump always wins over a branch when both are present.
    function automatic logic [1:0] redirect_src(input logic jmp);
        return jmp ? PC_SRC_JMP : PC_SRC_BR;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and controller outputs.
// master = pipeline datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] ifid_rs_i;
    logic [REG_W-1:0] ifid_rt_i;
    logic             ifid_uses_rt_i;
    logic [REG_W-1:0] idex_rt_i;
    logic             idex_memread_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             mem_busy_i;

    logic             pc_write_o;
    logic [1:0]       pc_src_o;
    logic             ifid_write_o;
    logic             pipe_stall_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             exmem_flush_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_rt_i, idex_memread_i,
               branch_taken_i, jump_i, mem_busy_i,
        input  pc_write_o, pc_src_o, ifid_write_o, pipe_stall_o, ifid_flush_o,
               idex_flush_o, exmem_flush_o, timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_rt_i, idex_memread_i,
               branch_taken_i, jump_i, mem_busy_i,
        output pc_write_o, pc_src_o, ifid_write_o, pipe_stall_o, ifid_flush_o,
               idex_flush_o, exmem_flush_o, timeout_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use detector: the load in EX writes a register the ID instruction reads.
// Register 0 is hardwired, so a load targeting it never creates a hazard.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_ifid_rs,
    input  logic [REG_W-1:0] i_ifid_rt,
    input  logic             i_ifid_uses_rt,
    input  logic [REG_W-1:0] i_idex_rt,
    input  logic             i_idex_memread,
    output logic             o_load_use
);
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_dst_live;

    assign w_dst_live = (i_idex_rt != '0);
    assign w_rs_hit   = (i_idex_rt == i_ifid_rs);
    assign w_rt_hit   = i_ifid_uses_rt & (i_idex_rt == i_ifid_rt);
    assign o_load_use = i_idex_memread & w_dst_live & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline (load-use, MEM-stage
// redirects, data-memory wait with timeout). Optional perf counters: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int                 WCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_br_pend;
    logic              r_jmp_pend;
    logic              w_br_pend_nxt;
    logic              w_jmp_pend_nxt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [WCNT_W-1:0] w_wait_cnt_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;

    logic              w_load_use;
    action_t           w_run_action;
    action_t           w_action;
    logic [1:0]        w_redir_src;

    logic              w_pc_write;
    logic [1:0]        w_pc_src;
    logic              w_ifid_write;
    logic              w_pipe_stall;
    logic              w_ifid_flush;
    logic              w_idex_flush;
    logic              w_exmem_flush;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use (
        .i_ifid_rs      (bus.ifid_rs_i),
        .i_ifid_rt      (bus.ifid_rt_i),
        .i_ifid_uses_rt (bus.ifid_uses_rt_i),
        .i_idex_rt      (bus.idex_rt_i),
        .i_idex_memread (bus.idex_memread_i),
        .o_load_use     (w_load_use)
    );

    // Action the RUN rules pick for the current inputs, ignoring mem_busy_i.
    assign w_run_action = (bus.jump_i | bus.branch_taken_i) ? ACT_REDIRECT :
                          w_load_use                        ? ACT_BUBBLE   :
                                                              ACT_SEQ;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_RUN;
            r_br_pend  <= 1'b0;
            r_jmp_pend <= 1'b0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_br_pend  <= w_br_pend_nxt;
            r_jmp_pend <= w_jmp_pend_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_br_pend_nxt  = r_br_pend;
        w_jmp_pend_nxt = r_jmp_pend;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;
        w_action       = ACT_SEQ;
        w_redir_src    = PC_SRC_SEQ;

        case (r_state)
            ST_RUN: begin
                if (bus.mem_busy_i) begin
                    w_action       = ACT_FREEZE;
                    w_br_pend_nxt  = bus.branch_taken_i;
                    w_jmp_pend_nxt = bus.jump_i;
                    w_wait_cnt_nxt = WAIT_ONE;
                    w_state_nxt    = ST_MEM_WAIT;
                end else begin
                    w_action    = w_run_action;
                    w_redir_src = redirect_src(bus.jump_i);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_busy_i) begin
                    w_action = ACT_FREEZE;
                    if (r_wait_cnt != WAIT_MAX) begin
                        w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
                    end
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_timeout_nxt = 1'b1;
                    end
                end else begin
                    // Redirect captured on entry takes precedence over live inputs.
                    if (r_jmp_pend | r_br_pend) begin
                        w_action    = ACT_REDIRECT;
                        w_redir_src = redirect_src(r_jmp_pend);
                    end else begin
                        w_action    = w_run_action;
                        w_redir_src = redirect_src(bus.jump_i);
                    end
                    w_br_pend_nxt  = 1'b0;
                    w_jmp_pend_nxt = 1'b0;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = ST_RUN;
                end
            end
            default: begin
                w_br_pend_nxt  = 1'b0;
                w_jmp_pend_nxt = 1'b0;
                w_wait_cnt_nxt = '0;
                w_state_nxt    = ST_RUN;
            end
        endcase
    end

    always_comb begin
        w_pc_write    = 1'b1;
        w_pc_src      = PC_SRC_SEQ;
        w_ifid_write  = 1'b1;
        w_pipe_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;

        if (!rst_i) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_pipe_stall = 1'b1;
        end else begin
            case (w_action)
                ACT_FREEZE: begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_pipe_stall = 1'b1;
                end
                ACT_BUBBLE: begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_idex_flush = 1'b1;
                end
                ACT_REDIRECT: begin
                    w_pc_src      = w_redir_src;
                    w_ifid_flush  = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_exmem_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write_o    = w_pc_write;
    assign bus.pc_src_o      = w_pc_src;
    assign bus.ifid_write_o  = w_ifid_write;
    assign bus.pipe_stall_o  = w_pipe_stall;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_flush_o  = w_idex_flush;
    assign bus.exmem_flush_o = w_exmem_flush;
    assign bus.timeout_o     = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_write) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_ifid_flush) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;
`else
    assign bus.stall_cnt_o = {CNT_W{1'b0}};
    assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios then random
// traffic, checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 6;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic [8:0]       ctrl;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
        int               idx;
    } exp_t;

    exp_t exp_q[$];

    int vectors    = 0;
    int miscompares = 0;
    int n_issued   = 0;

    // Model: count of consecutive busy cycles and the redirect seen when the wait began.
    int               m_busy_run = 0;
    bit               m_pbr      = 1'b0;
    bit               m_pjmp     = 1'b0;
    bit               m_to       = 1'b0;
    logic [CNT_W-1:0] m_scnt     = '0;
    logic [CNT_W-1:0] m_fcnt     = '0;

    task automatic step(input bit rst, input bit busy, input bit jmp, input bit br,
                        input bit mrd, input bit urt, input int rs, input int rt,
                        input int exrt);
        bit         pw, ifw, st, f1, f2, f3, lu;
        logic [1:0] src;
        exp_t       e;
        @(posedge clk_i);
        #1;
        rst_i              = rst;
        bus.mem_busy_i     = busy;
        bus.jump_i         = jmp;
        bus.branch_taken_i = br;
        bus.idex_memread_i = mrd;
        bus.ifid_uses_rt_i = urt;
        bus.ifid_rs_i      = REG_W'(rs);
        bus.ifid_rt_i      = REG_W'(rt);
        bus.idex_rt_i      = REG_W'(exrt);

        lu  = mrd && (exrt != 0) && ((exrt == rs) || (urt && (exrt == rt)));
        pw  = 1'b1; ifw = 1'b1; st = 1'b0;
        f1  = 1'b0; f2  = 1'b0; f3 = 1'b0;
        src = 2'd0;

        if (!rst) begin
            pw = 1'b0; ifw = 1'b0; st = 1'b1;
            m_busy_run = 0; m_pbr = 1'b0; m_pjmp = 1'b0; m_to = 1'b0;
            m_scnt = '0; m_fcnt = '0;
        end else if (busy) begin
            pw = 1'b0; ifw = 1'b0; st = 1'b1;
        end else if (m_busy_run > 0 && (m_pbr || m_pjmp)) begin
            f1 = 1'b1; f2 = 1'b1; f3 = 1'b1;
            src = m_pjmp ? 2'd2 : 2'd1;
        end else if (jmp || br) begin
            f1 = 1'b1; f2 = 1'b1; f3 = 1'b1;
            src = jmp ? 2'd2 : 2'd1;
        end else if (lu) begin
            pw = 1'b0; ifw = 1'b0; f2 = 1'b1;
        end

        e.ctrl = {pw, src, ifw, st, f1, f2, f3, m_to};
        e.scnt = m_scnt;
        e.fcnt = m_fcnt;
        e.idx  = n_issued;
        n_issued++;
        exp_q.push_back(e);

        if (rst) begin
`ifdef HAZARD_PERF_CNT_EN
            if (!pw) m_scnt = m_scnt + 1'b1;
            if (f1)  m_fcnt = m_fcnt + 1'b1;
`endif
            if (busy) begin
                if (m_busy_run == 0) begin
                    m_pbr  = br;
                    m_pjmp = jmp;
                end
                m_busy_run++;
                if (m_busy_run >= TIMEOUT) m_to = 1'b1;
            end else begin
                m_busy_run = 0;
                m_pbr      = 1'b0;
                m_pjmp     = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 1, 2, 3);
    endtask

    exp_t       mon_e;
    logic [8:0] mon_act;

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = {bus.pc_write_o, bus.pc_src_o, bus.ifid_write_o, bus.pipe_stall_o,
                       bus.ifid_flush_o, bus.idex_flush_o, bus.exmem_flush_o, bus.timeout_o};
            vectors++;
            if (mon_act !== mon_e.ctrl) begin
                miscompares++;
                $display("FAIL ctrl vec %0d: got %b expected %b (pcw src ifw stall fif fid fex to)",
                         mon_e.idx, mon_act, mon_e.ctrl);
            end
            if (bus.stall_cnt_o !== mon_e.scnt) begin
                miscompares++;
                $display("FAIL stall_cnt vec %0d: got %0d expected %0d",
                         mon_e.idx, bus.stall_cnt_o, mon_e.scnt);
            end
            if (bus.flush_cnt_o !== mon_e.fcnt) begin
                miscompares++;
                $display("FAIL flush_cnt vec %0d: got %0d expected %0d",
                         mon_e.idx, bus.flush_cnt_o, mon_e.fcnt);
            end
        end
    end

    initial begin
        bit busy_r;
        bus.mem_busy_i     = 1'b0;
        bus.jump_i         = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.idex_memread_i = 1'b0;
        bus.ifid_uses_rt_i = 1'b0;
        bus.ifid_rs_i      = '0;
        bus.ifid_rt_i      = '0;
        bus.idex_rt_i      = '0;

        // Reset state, then normal flow.
        step(0, 1, 1, 1, 1, 1, 8, 8, 8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use on rs, on rt (used / unused), and with destination r0.
        step(1, 0, 0, 0, 1, 0, 8, 3, 8);
        step(1, 0, 0, 0, 0, 0, 8, 3, 8);
        step(1, 0, 0, 0, 1, 1, 4, 9, 9);
        step(1, 0, 0, 0, 1, 0, 4, 9, 9);
        step(1, 0, 0, 0, 1, 1, 0, 0, 0);

        // Branch, jump, both together, branch masking a load-use.
        step(1, 0, 0, 1, 0, 0, 1, 2, 3);
        idle(1);
        step(1, 0, 1, 1, 0, 0, 1, 2, 3);
        step(1, 0, 0, 1, 1, 0, 8, 2, 8);
        idle(1);

        // Plain memory wait of 5 cycles, then release.
        for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0, 0, 1, 2, 3);
        step(1, 0, 0, 0, 0, 0, 1, 2, 3);

        // Branch captured on entry, busy held 3 cycles; later branch/jump ignored.
        step(1, 1, 0, 1, 0, 0, 1, 2, 3);
        step(1, 1, 1, 0, 0, 0, 1, 2, 3);
        step(1, 1, 0, 0, 0, 0, 1, 2, 3);
        step(1, 0, 0, 0, 0, 0, 1, 2, 3);

        // Jump + branch on entry: jump wins at release.
        step(1, 1, 1, 1, 0, 0, 1, 2, 3);
        step(1, 0, 0, 0, 0, 0, 1, 2, 3);

        // No pending redirect: release applies live jump, then live load-use.
        step(1, 1, 0, 0, 0, 0, 1, 2, 3);
        step(1, 0, 1, 0, 0, 0, 1, 2, 3);
        step(1, 1, 0, 0, 0, 0, 1, 2, 3);
        step(1, 0, 0, 0, 1, 0, 5, 2, 5);
        idle(1);

        // Long wait: timeout sticks after the TIMEOUT-th busy cycle.
        for (int k = 0; k < 10; k++) step(1, 1, 0, 0, 0, 0, 1, 2, 3);
        idle(3);

        // Reset in the middle of a wait with a pending branch.
        step(1, 1, 0, 1, 0, 0, 1, 2, 3);
        step(1, 1, 0, 0, 0, 0, 1, 2, 3);
        step(0, 1, 0, 0, 0, 0, 1, 2, 3);
        step(0, 0, 0, 0, 0, 0, 1, 2, 3);
        idle(3);

        // Random traffic with bursty memory waits and rare resets.
        busy_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r      = ($urandom_range(0, 199) != 0);
            busy_r = busy_r ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            step(r, busy_r, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end

        for (int k = 0; k < 5; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_i);
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined MIPS core.
- Drives the program counter's write enable and next-PC select, plus the IF/ID, ID/EX and EX/MEM write and flush controls.
- Resolves three hazard sources: load-use, taken branch/jump (resolved in MEM), and multi-cycle data-memory wait.
- Holds a small FSM with a wait-timeout counter and a pending-branch latch.

Parameters:
- REG_W, 5, register-index width.
- TIMEOUT, 255, maximum MEM_WAIT cycles before timeout_o sets (≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- ifid_rs_i  in  REG_W  rs of the instruction in ID.
- ifid_rt_i  in  REG_W  rt of the instruction in ID.
- ifid_uses_rt_i  in  1  ID instruction reads rt.
- idex_rt_i  in  REG_W  destination rt of the instruction in EX.
- idex_memread_i  in  1  EX instruction is a load.
- branch_taken_i  in  1  MEM-stage branch taken.
- jump_i  in  1  MEM-stage jump.
- mem_busy_i  in  1  data memory not ready this cycle.
- pc_write_o  out  1  program counter write enable.
- pc_src_o  out  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = jump target.
- ifid_write_o  out  1  IF/ID write enable.
- pipe_stall_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- ifid_flush_o  out  1  flush IF/ID.
- idex_flush_o  out  1  flush ID/EX (bubble insert).
- exmem_flush_o  out  1  flush EX/MEM.
- timeout_o  out  1  sticky memory-wait timeout.
- stall_cnt_o  out  CNT_W  stall-cycle counter (optional).
- flush_cnt_o  out  CNT_W  flush-event counter (optional).

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state = RUN; br_pend = 0; jmp_pend = 0; wait_cnt = 0; timeout_o = 0; counters = 0.
  - While rst_i=0, outputs are forced: pc_write_o=0, ifid_write_o=0, pipe_stall_o=1, all flushes=0, pc_src_o=0.
- Outputs are combinational from state and inputs. Flops are state, wait_cnt, pending latches, timeout_o and counters.
- load_use = idex_memread_i & (idex_rt_i!=0) & ((idex_rt_i==ifid_rs_i) | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
- Priority inside RUN: mem_busy_i > jump_i > branch_taken_i > load_use.
- State RUN, one of the following applies:
  - mem_busy_i=1:
    - Freeze: pc_write_o=0, ifid_write_o=0, pipe_stall_o=1, no flush.
    - Latch br_pend=branch_taken_i, jmp_pend=jump_i; wait_cnt=1; next state MEM_WAIT.
  - jump_i=1 or branch_taken_i=1:
    - pc_write_o=1, pc_src_o=2 (jump) or 1 (branch).
    - All three flushes = 1; ifid_write_o=1.
    - Next state RUN (one-cycle redirect, 3-instruction penalty).
  - load_use=1:
    - pc_write_o=0, ifid_write_o=0, idex_flush_o=1, pipe_stall_o=0.
    - Next state RUN; the hazard clears naturally after one bubble.
  - otherwise: pc_write_o=1, ifid_write_o=1, pc_src_o=0, no flush/stall.
- State MEM_WAIT:
  - mem_busy_i=1: freeze as above; wait_cnt saturating increment. When wait_cnt==TIMEOUT-1 and mem_busy_i still 1, timeout_o is set (sticky until reset); the block stays in MEM_WAIT.
  - mem_busy_i=0 (release cycle):
    - If jmp_pend|br_pend, the redirect and flush are applied with pc_src from the latch (jump wins). Otherwise the RUN rules are applied to the current inputs, excluding mem_busy_i.
    - Latches and wait_cnt are cleared; next state RUN.
- Branch/jump asserted during MEM_WAIT (after entry) is ignored; the pipeline is frozen, so only the entry-cycle value is valid.
- Reset mid-MEM_WAIT discards pending redirects. The counters and timeout_o are cleared.
- Illegal state encodings recover to RUN.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on every cycle with pc_write_o=0 and rst_i=1.
  - flush_cnt_o increments on every cycle with ifid_flush_o=1.
  - Both wrap at 2^CNT_W.
- Undefined: both outputs tied to 0; no counter flops are synthesized.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding localparams ST_RUN=1'b0, ST_MEM_WAIT=1'b1.
  - PC_SRC_SEQ=2'd0, PC_SRC_BR=2'd1, PC_SRC_JMP=2'd2.
- One natural sub-module, load_use_detect: the purely combinational compare producing load_use. The FSM, latches and counters stay in the top.

Test Plan:
- Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> exactly 1 cycle with pc_write_o=0, ifid_write_o=0, idex_flush_o=1. With idex_rt_i=0, no stall.
- Branch: branch_taken_i=1 for 1 cycle -> pc_src_o=1, pc_write_o=1, all three flushes=1 in that cycle only. branch_taken_i=1 with jump_i=1 -> pc_src_o=2.
- Memory wait: mem_busy_i=1 for 5 cycles -> pc_write_o=0 and pipe_stall_o=1 for all 5 cycles. On the release cycle pc_write_o=1; timeout_o stays 0.
- Pending branch: mem_busy_i=1 and branch_taken_i=1 in the same cycle, busy held 3 cycles -> no flush while busy; on the release cycle all flushes=1 and pc_src_o=1.
- Timeout: TIMEOUT=4, mem_busy_i held 10 cycles -> timeout_o rises after the 4th busy cycle and stays 1 until rst_i=0.
- Async reset: assert rst_i=0 mid-MEM_WAIT between clock edges -> outputs take reset values immediately. After release, state is RUN, pc_write_o=1, and (with HAZARD_PERF_CNT_EN) stall_cnt_o=0.
